// File: rtl/flush_pkg.sv
// Shared definitions for the frame flusher slice.
// Contents:
//    SCREEN_W / SCREEN_H  raster dimensions (columns / rows)
//    COORD_W / COLOUR_W   coordinate and colour bus widths
//    BG_COLOUR            colour written where no graphic claims a pixel
//    state_t              frame FSM encoding (IDLE / SCAN / DONE)
package flush_pkg;
   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int COORD_W  = 8;
   localparam int COLOUR_W = 6;
   localparam logic [COLOUR_W-1:0] BG_COLOUR = 6'b000000;

   typedef logic [COORD_W-1:0]  coord_t;
   typedef logic [COLOUR_W-1:0] colour_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/frame_flusher_if.sv
// Bus bundle between the frame flusher, the sprite graphic layer and the
// VGA adapter write port.
// Signals:
//    start, ready            frame request / downstream accept
//    pix_colour, pix_enable  graphic layer answer for (flush_x, flush_y)
//    flush_x, flush_y        scan coordinate presented to the graphic layer
//    vga_x, vga_y, vga_colour, vga_plot  registered VGA write port
//    busy, done              frame status
// Modports: master = the flusher, slave = the surrounding system.
interface frame_flusher_if;
   import flush_pkg::*;

   logic    start;
   logic    ready;
   colour_t pix_colour;
   logic    pix_enable;
   coord_t  flush_x;
   coord_t  flush_y;
   coord_t  vga_x;
   coord_t  vga_y;
   colour_t vga_colour;
   logic    vga_plot;
   logic    busy;
   logic    done;

   modport master (
      input  start, ready, pix_colour, pix_enable,
      output flush_x, flush_y, vga_x, vga_y, vga_colour, vga_plot, busy, done
   );

   modport slave (
      output start, ready, pix_colour, pix_enable,
      input  flush_x, flush_y, vga_x, vga_y, vga_colour, vga_plot, busy, done
   );
endinterface

// File: rtl/raster_counter.sv
// Raster-order (x fastest) coordinate counter.
// Ports:
//    clk, resetn   clock, asynchronous active-low reset
//    clear         force (0,0)
//    advance       step to the next raster position
//    x, y          current position (straight from the registers)
//    last          current position is the final pixel (W-1, H-1)
module raster_counter
   import flush_pkg::*;
#(
   parameter int W  = SCREEN_W,
   parameter int H  = SCREEN_H,
   parameter int CW = COORD_W
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          clear,
   input  logic          advance,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          last
);
   localparam logic [CW-1:0] X_LAST = CW'(W - 1);
   localparam logic [CW-1:0] Y_LAST = CW'(H - 1);

   logic [CW-1:0] x_q, x_d;
   logic [CW-1:0] y_q, y_d;

   // Wrapping is done by comparing against the last index so non power-of-2
   // dimensions work without relying on counter overflow.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clear) begin
         x_d = '0;
         y_d = '0;
      end else if (advance) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) y_d = '0;
            else               y_d = y_q + CW'(1);
         end else begin
            x_d = x_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign x    = x_q;
   assign y    = y_q;
   assign last = (x_q == X_LAST) && (y_q == Y_LAST);
endmodule

// File: rtl/frame_flusher.sv
// Frame flusher: sweeps the flush coordinate over the whole screen once per
// start request, samples the graphic layer's colour/enable for that
// coordinate and writes the pixel (or the background colour) to the VGA
// adapter one cycle later. ready=0 stalls the sweep without losing pixels.
// Ports:
//    clk     system clock (rising edge)
//    resetn  asynchronous active-low reset; aborts any frame in progress
//    bus     frame_flusher_if.master (see interface file for signal list)
module frame_flusher
   import flush_pkg::*;
#(
   parameter int      SCREEN_W_P  = SCREEN_W,
   parameter int      SCREEN_H_P  = SCREEN_H,
   parameter colour_t BG_COLOUR_P = BG_COLOUR
) (
   input  logic            clk,
   input  logic            resetn,
   frame_flusher_if.master bus
);
   state_t  state_q, state_d;
   coord_t  vga_x_q, vga_x_d;
   coord_t  vga_y_q, vga_y_d;
   colour_t vga_colour_q, vga_colour_d;
   logic    vga_plot_q, vga_plot_d;

   logic    cnt_clear;
   logic    cnt_advance;
   logic    cnt_last;
   coord_t  cnt_x;
   coord_t  cnt_y;

   raster_counter #(
      .W  (SCREEN_W_P),
      .H  (SCREEN_H_P),
      .CW (COORD_W)
   ) u_raster_counter (
      .clk     (clk),
      .resetn  (resetn),
      .clear   (cnt_clear),
      .advance (cnt_advance),
      .x       (cnt_x),
      .y       (cnt_y),
      .last    (cnt_last)
   );

   always_comb begin
      state_d      = state_q;
      cnt_clear    = 1'b0;
      cnt_advance  = 1'b0;
      vga_x_d      = vga_x_q;
      vga_y_d      = vga_y_q;
      vga_colour_d = vga_colour_q;
      vga_plot_d   = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_clear = 1'b1;
            if (bus.start) state_d = SCAN;
         end
         SCAN: begin
            // Graphic answer is combinational on flush_x/flush_y, so it is
            // captured in the same cycle the coordinate is presented.
            if (bus.ready) begin
               vga_x_d      = cnt_x;
               vga_y_d      = cnt_y;
               vga_colour_d = bus.pix_enable ? bus.pix_colour : BG_COLOUR_P;
               vga_plot_d   = 1'b1;
               cnt_advance  = 1'b1;
               // Counter wraps itself back to (0,0) on this capture.
               if (cnt_last) state_d = DONE;
            end
         end
         DONE: begin
            cnt_clear = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_colour_q <= '0;
         vga_plot_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         vga_x_q      <= vga_x_d;
         vga_y_q      <= vga_y_d;
         vga_colour_q <= vga_colour_d;
         vga_plot_q   <= vga_plot_d;
      end
   end

   assign bus.flush_x    = cnt_x;
   assign bus.flush_y    = cnt_y;
   assign bus.vga_x      = vga_x_q;
   assign bus.vga_y      = vga_y_q;
   assign bus.vga_colour = vga_colour_q;
   assign bus.vga_plot   = vga_plot_q;
   assign bus.busy       = (state_q == SCAN);
   assign bus.done       = (state_q == DONE);
endmodule

// File: tb/tb_frame_flusher.sv
// Directed testbench for frame_flusher: reset state, full frames with and
// without a two-pixel sprite, a 3-cycle ready stall, ignored start pulses,
// and a mid-frame reset abort followed by a clean full frame.
module tb_frame_flusher;
   import flush_pkg::*;

   localparam int TOTAL = SCREEN_W * SCREEN_H;

   logic clk = 1'b0;
   logic resetn;
   bit   sprite_mode;
   int   n_cmp = 0;
   int   n_bad = 0;

   frame_flusher_if ffi ();

   frame_flusher dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (ffi)
   );

   always #5 clk = ~clk;

   // Graphic-layer stub: claims (12,20) and (13,21) in sprite mode. The
   // colour bus carries non-background junk elsewhere so the enable mux
   // is exercised.
   always @* begin
      if (sprite_mode &&
          ((ffi.flush_x == 8'd12 && ffi.flush_y == 8'd20) ||
           (ffi.flush_x == 8'd13 && ffi.flush_y == 8'd21))) begin
         ffi.pix_enable = 1'b1;
         ffi.pix_colour = 6'h3F;
      end else begin
         ffi.pix_enable = 1'b0;
         ffi.pix_colour = ffi.flush_x[5:0] ^ ffi.flush_y[5:0] ^ 6'h15;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] exp_colour(input int x, input int y);
      if (sprite_mode && ((x == 12 && y == 20) || (x == 13 && y == 21)))
         return 6'h3F;
      return BG_COLOUR;
   endfunction

   task automatic run_frame(input string name, input bit sprite, input bit stall,
                            input bit poke, input bit abort);
      int   cx = 0, cy = 0, plots = 0, stalls = 0, hits = 0;
      bit   fin = 1'b0;
      logic [7:0] lx = 8'd0, ly = 8'd0;
      logic [5:0] ecol;
      sprite_mode = sprite;
      @(negedge clk);
      ffi.start = 1'b1;
      ffi.ready = 1'b1;
      @(posedge clk); #1;
      check("scan_entry", 32'({ffi.busy, ffi.vga_plot, ffi.flush_x, ffi.flush_y}), 32'({1'b1, 1'b0, 16'd0}));
      @(negedge clk);
      for (int cyc = 0; cyc < 25000; cyc++) begin
         ffi.start = poke && (cyc == 1000);
         check("flush_xy", 32'({ffi.flush_x, ffi.flush_y}), 32'({8'(cx), 8'(cy)}));
         if (abort && cx == 80 && cy == 60) begin
            resetn = 1'b0;
            #1;
            check("abort_outputs", 32'({ffi.vga_x, ffi.vga_y, ffi.vga_colour, ffi.vga_plot}), 32'd0);
            check("abort_flush", 32'({ffi.flush_x, ffi.flush_y, ffi.busy, ffi.done}), 32'd0);
            ffi.start = 1'b0;
            #2 resetn = 1'b1;
            @(posedge clk); #1;
            check("abort_idle", 32'({ffi.busy, ffi.vga_plot, ffi.flush_x, ffi.flush_y}), 32'd0);
            fin = 1'b1;
            break;
         end
         if (stall && cx == 50 && cy == 7 && stalls < 3) begin
            ffi.ready = 1'b0;
            stalls++;
         end else begin
            ffi.ready = 1'b1;
         end
         @(posedge clk); #1;
         if (ffi.ready) begin
            ecol = exp_colour(cx, cy);
            check("pixel", 32'({ffi.vga_plot, ffi.vga_x, ffi.vga_y, ffi.vga_colour}),
                  32'({1'b1, 8'(cx), 8'(cy), ecol}));
            if (ffi.vga_colour == 6'h3F) hits++;
            lx = 8'(cx);
            ly = 8'(cy);
            plots++;
            cx++;
            if (cx == SCREEN_W) begin
               cx = 0;
               cy++;
               if (cy == SCREEN_H) cy = 0;
            end
            if (plots == TOTAL) begin
               check("done_pulse", 32'({ffi.done, ffi.busy}), 32'({1'b1, 1'b0}));
               fin = 1'b1;
               break;
            end
            check("scan_status", 32'({ffi.done, ffi.busy}), 32'({1'b0, 1'b1}));
         end else begin
            check("stall_hold", 32'({ffi.vga_plot, ffi.vga_x, ffi.vga_y}), 32'({1'b0, lx, ly}));
         end
         @(negedge clk);
      end
      check("frame_finished", 32'(fin), 32'd1);
      if (fin && !abort) begin
         @(negedge clk);
         ffi.start = poke;
         @(posedge clk); #1;
         check("after_done", 32'({ffi.done, ffi.busy, ffi.vga_plot, ffi.flush_x, ffi.flush_y}), 32'd0);
         @(negedge clk);
         ffi.start = 1'b0;
         @(posedge clk); #1;
         check("idle_stays", 32'({ffi.done, ffi.busy, ffi.vga_plot}), 32'd0);
         check("plot_count", 32'(plots), 32'(TOTAL));
         if (sprite) check("sprite_hits", 32'(hits), 32'd2);
         if (stall) check("stall_cycles", 32'(stalls), 32'd3);
      end
      $display("frame %s: plots=%0d stalls=%0d sprite_hits=%0d", name, plots, stalls, hits);
   endtask

   initial begin
      resetn      = 1'b0;
      sprite_mode = 1'b0;
      ffi.start   = 1'b0;
      ffi.ready   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_vga", 32'({ffi.vga_x, ffi.vga_y, ffi.vga_colour, ffi.vga_plot}), 32'd0);
      check("reset_status", 32'({ffi.flush_x, ffi.flush_y, ffi.busy, ffi.done}), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("idle_hold", 32'({ffi.flush_x, ffi.flush_y, ffi.vga_plot, ffi.busy, ffi.done}), 32'd0);
      end
      $display("step reset: idle for 10 cycles");

      run_frame("sprite_stall_poke", 1'b1, 1'b1, 1'b1, 1'b0);
      run_frame("abort_at_80_60",    1'b1, 1'b0, 1'b0, 1'b1);
      run_frame("plain_after_abort", 1'b0, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
